// File: rtl/gpio_wb_cfg_seq_if.sv
// Wishbone master port of the GPIO configuration sequencer.
// master: drives cyc/stb/we/sel/adr/dat_o, samples dat_i/ack.
// slave : the GPIO block side (or a bench model of it).
interface gpio_wb_cfg_seq_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/gpio_wb_cfg_seq.sv
// Wishbone master sequencer that programs the 38-bit GPIO block in one go:
// IO_L, IO_H, OEB_L, OEB_H (values before enables), then optionally reads
// OEB_L/OEB_H back and compares them against what was written.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-low reset
//   start, verify          begin a sequence / add readback steps (IDLE only)
//   cfg_io, cfg_oeb        38-bit output value and output-enable-bar value
//   busy, done             sequence in progress / one-cycle completion pulse
//   err_code, err_step     00 ok, 01 timeout, 10 mismatch; failing step index
//   wbm                    Wishbone master port (gpio_wb_cfg_seq_if.master)
module gpio_wb_cfg_seq #(
    parameter logic [31:0] GPIO_BASE      = 32'h300FFFE8,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic        verify,
    input  logic [37:0] cfg_io,
    input  logic [37:0] cfg_oeb,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [2:0]  err_step,
    gpio_wb_cfg_seq_if.master wbm
);

    typedef enum logic [1:0] {IDLE, XFER, GAP, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [2:0]  step;
    logic [7:0]  tmo_cnt;
    logic [37:0] io_q;
    logic [37:0] oeb_q;
    logic        verify_q;

    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;

    logic [2:0]  step_nxt;
    logic [2:0]  last_step;

    assign step_nxt  = step + 3'd1;
    assign last_step = verify_q ? 3'd5 : 3'd3;

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = stb_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

    // Register address of each step. Steps 4/5 read back OEB_L/OEB_H.
    function automatic logic [31:0] step_adr(input logic [2:0] s);
        case (s)
            3'd0:       step_adr = GPIO_BASE + 32'd8;
            3'd1:       step_adr = GPIO_BASE + 32'd12;
            3'd2, 3'd4: step_adr = GPIO_BASE + 32'd4;
            default:    step_adr = GPIO_BASE;
        endcase
    endfunction

    // Write data for steps 0..3, expected read data for steps 4/5.
    function automatic logic [31:0] step_dat(input logic [2:0] s,
                                             input logic [37:0] io,
                                             input logic [37:0] oeb);
        case (s)
            3'd0:       step_dat = io[31:0];
            3'd1:       step_dat = {26'b0, io[37:32]};
            3'd2, 3'd4: step_dat = oeb[31:0];
            default:    step_dat = {26'b0, oeb[37:32]};
        endcase
    endfunction

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state    <= IDLE;
            step     <= 3'd0;
            tmo_cnt  <= 8'd0;
            io_q     <= '0;
            oeb_q    <= '0;
            verify_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_code <= 2'b00;
            err_step <= 3'd0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= 4'h0;
            adr_q    <= 32'h0;
            dat_q    <= 32'h0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        io_q     <= cfg_io;
                        oeb_q    <= cfg_oeb;
                        verify_q <= verify;
                        err_code <= 2'b00;
                        err_step <= 3'd0;
                        step     <= 3'd0;
                        tmo_cnt  <= 8'd0;
                        busy     <= 1'b1;
                        state    <= XFER;
                        // Step 0 is a write; the raw inputs are used because
                        // the captured copies land on this same edge.
                        cyc_q    <= 1'b1;
                        stb_q    <= 1'b1;
                        we_q     <= 1'b1;
                        sel_q    <= 4'hF;
                        adr_q    <= step_adr(3'd0);
                        dat_q    <= step_dat(3'd0, cfg_io, cfg_oeb);
                    end
                end

                XFER: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (wbm.wbm_ack_i || tmo_cnt == TMO_LAST) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= 4'h0;
                        adr_q <= 32'h0;
                        dat_q <= 32'h0;
                    end
                    if (wbm.wbm_ack_i) begin
                        if (!we_q && wbm.wbm_dat_i != step_dat(step, io_q, oeb_q)) begin
                            err_code <= 2'b10;
                            err_step <= step;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else if (step == last_step) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= GAP;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_code <= 2'b01;
                        err_step <= step;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end

                // One idle bus cycle between steps so the slave can drop ack.
                GAP: begin
                    step    <= step_nxt;
                    tmo_cnt <= 8'd0;
                    state   <= XFER;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    we_q    <= ~step_nxt[2];
                    sel_q   <= 4'hF;
                    adr_q   <= step_adr(step_nxt);
                    dat_q   <= step_nxt[2] ? 32'h0 : step_dat(step_nxt, io_q, oeb_q);
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_wb_cfg_seq.sv
// Scoreboard bench for gpio_wb_cfg_seq: directed sequences push expected bus
// transfers and completion results into queues; a monitor pops and compares
// them whenever the DUT completes a transfer or pulses done.
module tb_gpio_wb_cfg_seq;

    localparam logic [31:0] A_OEB_H = 32'h300FFFE8;
    localparam logic [31:0] A_OEB_L = 32'h300FFFEC;
    localparam logic [31:0] A_IO_L  = 32'h300FFFF0;
    localparam logic [31:0] A_IO_H  = 32'h300FFFF4;

    typedef struct { logic [31:0] adr; logic we; logic [31:0] dat; } xfer_t;
    typedef struct { logic [1:0] code; logic [2:0] step; int cyc; } done_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        verify;
    logic [37:0] cfg_io;
    logic [37:0] cfg_oeb;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [2:0]  err_step;

    gpio_wb_cfg_seq_if bus();

    gpio_wb_cfg_seq dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .start    (start),
        .verify   (verify),
        .cfg_io   (cfg_io),
        .cfg_oeb  (cfg_oeb),
        .busy     (busy),
        .done     (done),
        .err_code (err_code),
        .err_step (err_step),
        .wbm      (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int ecount = 0;
    int t0     = 0;
    int ndone  = 0;
    int n_stb_oebl = 0;
    int n_stb_oebh = 0;

    xfer_t xq[$];
    done_t dq[$];

    always @(posedge clk) ecount <= ecount + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- GPIO slave model: acks one cycle after strobe ----------
    logic        ack = 1'b0;
    logic        stall_en = 1'b0;   // never ack OEB_L
    logic        force_h = 1'b0;    // corrupt OEB_H readback
    logic [31:0] r_io_l = 0, r_io_h = 0, r_oeb_l = 0, r_oeb_h = 0;

    assign bus.wbm_ack_i = ack;
    assign bus.wbm_dat_i = (bus.wbm_adr_o == A_OEB_L) ? r_oeb_l :
                           (bus.wbm_adr_o == A_OEB_H) ? (force_h ? 32'h3F : r_oeb_h) :
                           (bus.wbm_adr_o == A_IO_L)  ? r_io_l : r_io_h;

    always @(posedge clk) begin
        if (!rst) ack <= 1'b0;
        else begin
            ack <= bus.wbm_cyc_o && bus.wbm_stb_o && !ack &&
                   !(stall_en && bus.wbm_adr_o == A_OEB_L);
            if (bus.wbm_cyc_o && bus.wbm_stb_o && ack && bus.wbm_we_o) begin
                case (bus.wbm_adr_o)
                    A_IO_L:  r_io_l  <= bus.wbm_dat_o;
                    A_IO_H:  r_io_h  <= bus.wbm_dat_o;
                    A_OEB_L: r_oeb_l <= bus.wbm_dat_o;
                    A_OEB_H: r_oeb_h <= bus.wbm_dat_o;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_adr_o == A_OEB_L) n_stb_oebl++;
            if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_adr_o == A_OEB_H) n_stb_oebh++;
            if (bus.wbm_cyc_o && bus.wbm_stb_o && bus.wbm_ack_i) begin
                if (xq.size() == 0) chk("xfer_unexpected", 64'(bus.wbm_adr_o), 64'h0);
                else begin
                    xfer_t e;
                    e = xq.pop_front();
                    chk("xfer_adr", 64'(bus.wbm_adr_o), 64'(e.adr));
                    chk("xfer_we",  64'(bus.wbm_we_o),  64'(e.we));
                    chk("xfer_dat", 64'(bus.wbm_dat_o), 64'(e.dat));
                    chk("xfer_sel", 64'(bus.wbm_sel_o), 64'hF);
                end
            end
            if (done) begin
                ndone++;
                if (dq.size() == 0) chk("done_unexpected", 64'(err_code), 64'h3);
                else begin
                    done_t d;
                    d = dq.pop_front();
                    chk("done_cycle", 64'(ecount - t0), 64'(d.cyc));
                    chk("err_code",   64'(err_code),    64'(d.code));
                    chk("err_step",   64'(err_step),    64'(d.step));
                    chk("busy_at_done", 64'(busy), 64'h1);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_x(input logic [31:0] a, input logic w, input logic [31:0] d);
        xfer_t e;
        e.adr = a; e.we = w; e.dat = d;
        xq.push_back(e);
    endtask

    task automatic push_d(input logic [1:0] c, input logic [2:0] s, input int cy);
        done_t d;
        d.code = c; d.step = s; d.cyc = cy;
        dq.push_back(d);
    endtask

    task automatic run(input logic [37:0] io, input logic [37:0] oeb, input logic v);
        @(negedge clk);
        cfg_io = io; cfg_oeb = oeb; verify = v; start = 1'b1;
        t0 = ecount;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int seen;
        int i;
        seen = ndone;
        i = 0;
        while (ndone == seen && i < budget) begin
            @(negedge clk); #1;
            i++;
        end
        if (ndone == seen) chk("done_wait_expired", 64'h0, 64'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        rst = 1'b0; start = 1'b0; verify = 1'b0; cfg_io = '0; cfg_oeb = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy_done", 64'({busy, done}), 64'h0);
        chk("rst_err", 64'({err_code, err_step}), 64'h0);
        chk("rst_bus_ctl", 64'({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}), 64'h0);
        chk("rst_bus_adr", 64'(bus.wbm_adr_o), 64'h0);
        chk("rst_bus_dat", 64'(bus.wbm_dat_o), 64'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write
        push_x(A_IO_L, 1, 32'hDEADBEEF); push_x(A_IO_H, 1, 32'h2A);
        push_x(A_OEB_L, 1, 32'h0);       push_x(A_OEB_H, 1, 32'h0);
        push_d(2'b00, 3'd0, 12);
        run(38'h2A_DEADBEEF, 38'h0, 1'b0);
        wait_done(40);
        repeat (2) @(negedge clk);
        chk("basic_io_out", 64'({r_io_h[5:0], r_io_l}), 64'h2A_DEADBEEF);
        chk("basic_io_oeb", 64'({r_oeb_h[5:0], r_oeb_l}), 64'h0);
        chk("basic_idle", 64'({busy, bus.wbm_cyc_o}), 64'h0);

        // Verify pass
        push_x(A_IO_L, 1, 32'h00000001); push_x(A_IO_H, 1, 32'h01);
        push_x(A_OEB_L, 1, 32'h0000FFFF); push_x(A_OEB_H, 1, 32'h15);
        push_x(A_OEB_L, 0, 32'h0);        push_x(A_OEB_H, 0, 32'h0);
        push_d(2'b00, 3'd0, 18);
        run(38'h01_00000001, 38'h15_0000FFFF, 1'b1);
        wait_done(60);
        repeat (2) @(negedge clk);
        chk("verify_oeb_l", 64'(r_oeb_l), 64'h0000FFFF);
        chk("verify_oeb_h", 64'(r_oeb_h), 64'h15);

        // Verify mismatch on OEB_H readback
        force_h = 1'b1;
        push_x(A_IO_L, 1, 32'h00000001); push_x(A_IO_H, 1, 32'h01);
        push_x(A_OEB_L, 1, 32'h0000FFFF); push_x(A_OEB_H, 1, 32'h15);
        push_x(A_OEB_L, 0, 32'h0);        push_x(A_OEB_H, 0, 32'h0);
        push_d(2'b10, 3'd5, 18);
        run(38'h01_00000001, 38'h15_0000FFFF, 1'b1);
        wait_done(60);
        force_h = 1'b0;
        repeat (2) @(negedge clk);

        // Timeout on step 2: strobe cycles 7..22, done in 23, step 3 never issued
        stall_en = 1'b1;
        n_stb_oebl = 0; n_stb_oebh = 0;
        push_x(A_IO_L, 1, 32'h12345678); push_x(A_IO_H, 1, 32'h3F);
        push_d(2'b01, 3'd2, 23);
        run(38'h3F_12345678, 38'h2A_AAAA5555, 1'b0);
        wait_done(80);
        chk("tmo_cyc_low", 64'({bus.wbm_cyc_o, bus.wbm_stb_o}), 64'h0);
        repeat (4) @(negedge clk);
        chk("tmo_stb_cycles", 64'(n_stb_oebl), 64'd16);
        chk("tmo_no_step3", 64'(n_stb_oebh), 64'd0);
        stall_en = 1'b0;

        // Start while busy: second start in cycle 5 must be ignored
        push_x(A_IO_L, 1, 32'hCAFEF00D); push_x(A_IO_H, 1, 32'h11);
        push_x(A_OEB_L, 1, 32'hFFFF0000); push_x(A_OEB_H, 1, 32'h3F);
        push_d(2'b00, 3'd0, 12);
        run(38'h11_CAFEF00D, 38'h3F_FFFF0000, 1'b0);
        while (ecount - t0 < 5) @(negedge clk);
        cfg_io = 38'h05_01010101; cfg_oeb = 38'h00_00000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40);
        repeat (3) @(negedge clk);
        chk("busy_start_io", 64'({r_io_h[5:0], r_io_l}), 64'h11_CAFEF00D);
        chk("busy_start_oeb", 64'({r_oeb_h[5:0], r_oeb_l}), 64'h3F_FFFF0000);
        chk("busy_start_idle", 64'(busy), 64'h0);

        // Reset in cycle 7 (step 2 strobing); steps 0,1 have completed
        push_x(A_IO_L, 1, 32'h0BADC0DE); push_x(A_IO_H, 1, 32'h22);
        run(38'h22_0BADC0DE, 38'h01_00000000, 1'b1);
        while (ecount - t0 < 7) @(negedge clk);
        nd = ndone;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_bus", 64'({bus.wbm_cyc_o, bus.wbm_stb_o}), 64'h0);
        chk("rstmid_busy_done", 64'({busy, done}), 64'h0);
        rst = 1'b1;
        chk("rstmid_xq_drained", 64'(xq.size()), 64'd0);
        repeat (4) @(negedge clk);
        chk("rstmid_no_done", 64'(ndone - nd), 64'd0);

        // Restart after reset completes normally
        push_x(A_IO_L, 1, 32'h89ABCDEF); push_x(A_IO_H, 1, 32'h07);
        push_x(A_OEB_L, 1, 32'h00FF00FF); push_x(A_OEB_H, 1, 32'h08);
        push_d(2'b00, 3'd0, 12);
        run(38'h07_89ABCDEF, 38'h08_00FF00FF, 1'b0);
        wait_done(40);
        repeat (2) @(negedge clk);
        chk("restart_io", 64'({r_io_h[5:0], r_io_l}), 64'h07_89ABCDEF);
        chk("restart_oeb", 64'({r_oeb_h[5:0], r_oeb_l}), 64'h08_00FF00FF);

        chk("end_xq_empty", 64'(xq.size()), 64'd0);
        chk("end_dq_empty", 64'(dq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
